// File: rtl/cnn_conv_mac_pkg.sv
// cnn_conv_mac_pkg
//   Shared configuration for the convolution MAC stage. Holds the CNNConfig
//   defines (KERNEL_SIZE, WINDOW_SIZE, KERNEL_WIDTH), the accumulator width,
//   the MAC FSM state encoding and the tap-mask helper.
//   Optional feature macro used by the MAC: CNN_MAC_RELU_EN.
//   Ports: none (package).

`ifndef KERNEL_SIZE
`define KERNEL_SIZE 3
`endif
`ifndef WINDOW_SIZE
`define WINDOW_SIZE (`KERNEL_SIZE * `KERNEL_SIZE)
`endif
`ifndef KERNEL_WIDTH
`define KERNEL_WIDTH $clog2(`KERNEL_SIZE + 1)
`endif

package cnn_conv_mac_pkg;

   localparam int unsigned KernelSize  = `KERNEL_SIZE;
   localparam int unsigned WindowSize  = `WINDOW_SIZE;
   localparam int unsigned KernelWidth = `KERNEL_WIDTH;
   localparam int unsigned MacAccW     = 64;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StLoad  = 2'd1,
      StRun   = 2'd2,
      StDrain = 2'd3
   } mac_state_e;

   // Tap (row, col) is live only inside the active kernel rectangle.
   function automatic logic tap_active(input int unsigned row, input int unsigned col,
                                       input logic [KernelWidth-1:0] width,
                                       input logic [KernelWidth-1:0] height);
      return (row < 32'(height)) && (col < 32'(width));
   endfunction

endpackage

// File: rtl/cnn_result_fifo.sv
// cnn_result_fifo
//   32-bit synchronous show-ahead FIFO; the head entry is visible on data_o
//   whenever empty_o is low. Depth must be a power of two so the pointers
//   wrap naturally. A push while full is taken only together with a pop.
//   Ports: clk_i, rst_i (sync, active-high), push_i/data_i (write),
//   pop_i (read), data_o (head, 0 when empty), count_o, full_o, empty_o.

module cnn_result_fifo #(
   parameter int unsigned Depth = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [31:0]              data_i,
   input  logic                     pop_i,
   output logic [31:0]              data_o,
   output logic [$clog2(Depth):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned AW = $clog2(Depth);

   logic [31:0]   mem_q [Depth];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   count_q;
   logic          do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW + 1)'(Depth));
   assign count_o = count_q;
   assign data_o  = empty_o ? 32'h0 : mem_q[rptr_q];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         if (do_push && !do_pop)      count_q <= count_q + (AW + 1)'(1);
         else if (!do_push && do_pop) count_q <= count_q - (AW + 1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/cnn_conv_mac.sv
// cnn_conv_mac
//   Masked dot product of one window against a preloaded kernel, followed by
//   arithmetic shift, 32-bit saturation and a result FIFO. Three pipeline
//   stages: masked products, adder-tree sum, shift/saturate into the FIFO.
//   Optional macro CNN_MAC_RELU_EN clamps negative results to 0.
//   Ports: clk, rst (sync, active-high); kernel_width_i/kernel_height_i/shift_i
//   captured on start; wt_valid/wt_data/wt_ready weight load; window/
//   window_valid/window_finish/window_stall input stream; result_valid/
//   result_ready/result_data output stream; done end-of-operation pulse.

module cnn_conv_mac
   import cnn_conv_mac_pkg::*;
#(
   parameter int unsigned KERNEL_SIZE = `KERNEL_SIZE,
   parameter int unsigned WINDOW_SIZE = KERNEL_SIZE * KERNEL_SIZE,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned ACC_W       = MacAccW
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [`KERNEL_WIDTH-1:0]     kernel_width_i,
   input  logic [`KERNEL_WIDTH-1:0]     kernel_height_i,
   input  logic [5:0]                   shift_i,
   input  logic                         start,
   input  logic                         wt_valid,
   input  logic [31:0]                  wt_data,
   output logic                         wt_ready,
   input  logic [WINDOW_SIZE-1:0][31:0] window,
   input  logic                         window_valid,
   input  logic                         window_finish,
   output logic                         window_stall,
   output logic                         result_valid,
   input  logic                         result_ready,
   output logic [31:0]                  result_data,
   output logic                         done
);

   localparam int unsigned IdxW   = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1;
   localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned Levels = $clog2(WINDOW_SIZE);
   localparam int unsigned NLeaf  = 1 << Levels;
   localparam logic signed [ACC_W-1:0] SatHi = {{(ACC_W - 31){1'b0}}, {31{1'b1}}};
   localparam logic signed [ACC_W-1:0] SatLo = {{(ACC_W - 31){1'b1}}, 31'b0};

   mac_state_e                  state_q, state_d;
   logic [`KERNEL_WIDTH-1:0]    width_q, height_q;
   logic [5:0]                  shift_q;
   logic [31:0]                 weight_q [WINDOW_SIZE];
   logic [IdxW-1:0]             idx_q;
   logic signed [ACC_W-1:0]     prod_d [WINDOW_SIZE];
   logic signed [ACC_W-1:0]     prod_q [WINDOW_SIZE];
   logic signed [ACC_W-1:0]     tree_sum, sum_q, shifted;
   logic [31:0]                 sat, res;
   logic                        v1_q, v2_q;
   logic [CntW-1:0]             pipe_q, fifo_count;
   logic [CntW:0]               occupancy;
   logic                        fifo_full, fifo_empty;
   logic                        busy, accept, wt_fire, start_fire;

   assign busy       = (state_q == StRun) || (state_q == StDrain);
   assign start_fire = (state_q == StIdle) && start;
   assign wt_ready   = (state_q == StLoad);
   assign wt_fire    = wt_valid & wt_ready;
   // Slots already promised to in-flight windows count as occupied.
   assign occupancy  = {1'b0, fifo_count} + {1'b0, pipe_q};
   assign window_stall = busy ? (fifo_full | (occupancy >= (CntW + 1)'(FIFO_DEPTH))) : 1'b1;
   assign accept     = window_valid & ~window_stall;
   assign result_valid = ~fifo_empty;

   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      unique case (state_q)
         StIdle:  if (start) state_d = StLoad;
         StLoad:  if (wt_fire && idx_q == IdxW'(WINDOW_SIZE - 1)) state_d = StRun;
         StRun:   if (window_finish) state_d = StDrain;
         StDrain: begin
            if (!window_valid && pipe_q == '0 && fifo_empty) begin
               state_d = StIdle;
               done    = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         pipe_q  <= '0;
      end else begin
         state_q <= state_d;
         if (start_fire)   idx_q <= '0;
         else if (wt_fire) idx_q <= idx_q + IdxW'(1);
         v1_q <= accept;
         v2_q <= v1_q;
         if (accept && !v2_q)      pipe_q <= pipe_q + CntW'(1);
         else if (!accept && v2_q) pipe_q <= pipe_q - CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (start_fire) begin
         width_q  <= kernel_width_i;
         height_q <= kernel_height_i;
         shift_q  <= shift_i;
      end
      if (wt_fire) weight_q[idx_q] <= wt_data;
      if (accept)  prod_q <= prod_d;
      if (v1_q)    sum_q  <= tree_sum;
   end

   for (genvar t = 0; t < WINDOW_SIZE; t++) begin : g_tap
      logic signed [63:0] prod;
      assign prod = 64'($signed(window[t])) * 64'($signed(weight_q[t]));
      assign prod_d[t] = tap_active(t / KERNEL_SIZE, t % KERNEL_SIZE, width_q, height_q)
                         ? ACC_W'(prod) : '0;
   end

   // Binary adder tree, leaves padded with zeros up to a power of two.
   for (genvar l = 0; l <= Levels; l++) begin : g_lvl
      logic signed [ACC_W-1:0] s [NLeaf >> l];
      for (genvar i = 0; i < (NLeaf >> l); i++) begin : g_node
         if (l == 0) begin : g_leaf
            if (i < WINDOW_SIZE) begin : g_real
               assign s[i] = prod_q[i];
            end else begin : g_pad
               assign s[i] = '0;
            end
         end else begin : g_add
            assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
         end
      end
   end
   assign tree_sum = g_lvl[Levels].s[0];

   always_comb begin
      shifted = sum_q >>> shift_q;
      if (shifted > SatHi)      sat = 32'h7fff_ffff;
      else if (shifted < SatLo) sat = 32'h8000_0000;
      else                      sat = shifted[31:0];
`ifdef CNN_MAC_RELU_EN
      res = sat[31] ? 32'h0 : sat;
`else
      res = sat;
`endif
   end

   cnn_result_fifo #(
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (v2_q),
      .data_i  (res),
      .pop_i   (result_valid & result_ready),
      .data_o  (result_data),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule

// File: tb/tb_cnn_conv_mac.sv
// tb_cnn_conv_mac
//   Directed self-checking bench for cnn_conv_mac with hand-computed results.

module tb_cnn_conv_mac;
   import cnn_conv_mac_pkg::*;

   localparam int unsigned WS = WindowSize;

   logic                   clk, rst, start, wt_valid, wt_ready;
   logic                   window_valid, window_finish, window_stall;
   logic                   result_valid, result_ready, done;
   logic [KernelWidth-1:0] kernel_width_i, kernel_height_i;
   logic [5:0]             shift_i;
   logic [31:0]            wt_data, result_data;
   logic [WS-1:0][31:0]    window;
   int                     n_checks, n_pass;

   cnn_conv_mac dut (
      .clk             (clk),
      .rst             (rst),
      .kernel_width_i  (kernel_width_i),
      .kernel_height_i (kernel_height_i),
      .shift_i         (shift_i),
      .start           (start),
      .wt_valid        (wt_valid),
      .wt_data         (wt_data),
      .wt_ready        (wt_ready),
      .window          (window),
      .window_valid    (window_valid),
      .window_finish   (window_finish),
      .window_stall    (window_stall),
      .result_valid    (result_valid),
      .result_ready    (result_ready),
      .result_data     (result_data),
      .done            (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef CNN_MAC_RELU_EN
      return v[31] ? 32'h0 : v;
`else
      return v;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int w, input int h, input int sh);
      kernel_width_i  = KernelWidth'(w);
      kernel_height_i = KernelWidth'(h);
      shift_i         = 6'(sh);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic load_weights(input logic [31:0] wv);
      wt_valid = 1'b1;
      wt_data  = wv;
      repeat (WS) tick();
      wt_valid = 1'b0;
   endtask

   task automatic wait_result(output bit ok, output logic [31:0] d);
      ok = 1'b0;
      d  = '0;
      for (int i = 0; i < 20; i++) begin
         if (result_valid === 1'b1) begin
            ok = 1'b1;
            d  = result_data;
            break;
         end
         tick();
      end
   endtask

   task automatic finish_op(output bit got);
      window_valid  = 1'b0;
      window_finish = 1'b1;
      result_ready  = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (done === 1'b1) begin
            got = 1'b1;
            tick();
            break;
         end
         tick();
      end
      window_finish = 1'b0;
      result_ready  = 1'b0;
   endtask

   // One window (current contents of `window`) through a full operation.
   task automatic run_single(input int w, input int h, input int sh, input logic [31:0] wv,
                             output bit ok, output logic [31:0] d, output bit got);
      do_start(w, h, sh);
      load_weights(wv);
      window_valid = 1'b1;
      tick();
      window_valid = 1'b0;
      wait_result(ok, d);
      finish_op(got);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      n_checks++; if (window_stall !== 1'b1) $display("FAIL reset_stall: got %b want 1", window_stall); else n_pass++;
      n_checks++; if (wt_ready !== 1'b0) $display("FAIL reset_wt_ready: got %b want 0", wt_ready); else n_pass++;
      n_checks++; if (result_valid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", result_valid); else n_pass++;
      n_checks++; if (result_data !== 32'h0) $display("FAIL reset_rdata: got %h want 0", result_data); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
      tick();
   endtask

   task automatic test_ones();
      bit got;
      do_start(3, 3, 0);
      n_checks++; if (wt_ready !== 1'b1) $display("FAIL ones_wt_ready: got %b want 1", wt_ready); else n_pass++;
      load_weights(32'd1);
      for (int t = 0; t < WS; t++) window[t] = 32'(t + 1);
      window_valid = 1'b1;
      n_checks++; if (window_stall !== 1'b0) $display("FAIL ones_stall: got %b want 0", window_stall); else n_pass++;
      tick();
      window_valid = 1'b0;
      n_checks++; if (result_valid !== 1'b0) $display("FAIL ones_lat1: got %b want 0", result_valid); else n_pass++;
      tick();
      n_checks++; if (result_valid !== 1'b0) $display("FAIL ones_lat2: got %b want 0", result_valid); else n_pass++;
      tick();
      n_checks++; if (result_valid !== 1'b1) $display("FAIL ones_lat3: got %b want 1", result_valid); else n_pass++;
      n_checks++; if (result_data !== 32'd45) $display("FAIL ones_data: got %0d want 45", result_data); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL ones_early_done: got %b want 0", done); else n_pass++;
      finish_op(got);
      n_checks++; if (got !== 1'b1) $display("FAIL ones_done: got %b want 1", got); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL ones_done_width: got %b want 0", done); else n_pass++;
      n_checks++; if (window_stall !== 1'b1) $display("FAIL ones_idle_stall: got %b want 1", window_stall); else n_pass++;
   endtask

   task automatic test_mask();
      bit ok, got;
      logic [31:0] d;
      for (int t = 0; t < WS; t++) window[t] = 32'd7;
      run_single(2, 1, 0, 32'd2, ok, d, got);
      n_checks++; if (!ok || d !== 32'd28) $display("FAIL mask_w2h1: got %0d (valid %b) want 28", d, ok); else n_pass++;
      for (int t = 0; t < WS; t++) window[t] = 32'h1234_5678;
      window[0] = 32'd7;
      window[1] = 32'd7;
      run_single(2, 1, 0, 32'd2, ok, d, got);
      n_checks++; if (!ok || d !== 32'd28) $display("FAIL mask_junk: got %0d (valid %b) want 28", d, ok); else n_pass++;
      for (int t = 0; t < WS; t++) window[t] = 32'(t + 1);
      run_single(1, 3, 0, 32'd1, ok, d, got);
      n_checks++; if (!ok || d !== 32'd12) $display("FAIL mask_w1h3: got %0d (valid %b) want 12", d, ok); else n_pass++;
      n_checks++; if (got !== 1'b1) $display("FAIL mask_done: got %b want 1", got); else n_pass++;
   endtask

   task automatic test_saturation();
      bit ok, got;
      logic [31:0] d;
      window = '0;
      window[0] = 32'h7fff_ffff;
      run_single(1, 1, 0, 32'h7fff_ffff, ok, d, got);
      n_checks++; if (!ok || d !== 32'h7fff_ffff) $display("FAIL sat_pos: got %h want 7fffffff", d); else n_pass++;
      run_single(1, 1, 31, 32'h7fff_ffff, ok, d, got);
      n_checks++; if (!ok || d !== 32'h7fff_fffe) $display("FAIL sat_shift31: got %h want 7ffffffe", d); else n_pass++;
      run_single(1, 1, 0, 32'h8000_0001, ok, d, got);
      n_checks++; if (!ok || d !== relu(32'h8000_0000)) $display("FAIL sat_neg: got %h want %h", d, relu(32'h8000_0000)); else n_pass++;
      window[0] = 32'hffff_fff8;
      run_single(1, 1, 2, 32'd1, ok, d, got);
      n_checks++; if (!ok || d !== relu(32'hffff_fffe)) $display("FAIL shift_m8: got %h want %h", d, relu(32'hffff_fffe)); else n_pass++;
      window[0] = 32'hffff_fff7;
      run_single(1, 1, 2, 32'd1, ok, d, got);
      n_checks++; if (!ok || d !== relu(32'hffff_fffd)) $display("FAIL shift_m9: got %h want %h", d, relu(32'hffff_fffd)); else n_pass++;
      n_checks++; if (got !== 1'b1) $display("FAIL sat_done: got %b want 1", got); else n_pass++;
   endtask

   task automatic test_back_to_back();
      bit got;
      do_start(2, 2, 1);
      load_weights(32'd3);
      result_ready = 1'b1;
      for (int t = 0; t < WS; t++) window[t] = 32'd100;
      window[0] = 32'd1; window[1] = 32'd2; window[3] = 32'd3; window[4] = 32'd4;
      window_valid = 1'b1;
      tick();
      window[0] = 32'hffff_fffb; window[1] = 32'hffff_fffa; window[3] = 32'd0; window[4] = 32'd2;
      kernel_width_i = KernelWidth'(1);
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++; if (wt_ready !== 1'b0) $display("FAIL b2b_start_ignored: got %b want 0", wt_ready); else n_pass++;
      window[0] = 32'd1000; window[1] = 32'd0; window[2] = 32'd999; window[3] = 32'd0; window[4] = 32'd0;
      tick();
      window_valid = 1'b0;
      n_checks++; if (result_valid !== 1'b1 || result_data !== 32'd15) $display("FAIL b2b_r0: got %0d (valid %b) want 15", result_data, result_valid); else n_pass++;
      tick();
      n_checks++; if (result_valid !== 1'b1 || result_data !== relu(32'hffff_fff2)) $display("FAIL b2b_r1: got %h (valid %b) want %h", result_data, result_valid, relu(32'hffff_fff2)); else n_pass++;
      tick();
      n_checks++; if (result_valid !== 1'b1 || result_data !== 32'd1500) $display("FAIL b2b_r2: got %0d (valid %b) want 1500", result_data, result_valid); else n_pass++;
      tick();
      n_checks++; if (result_valid !== 1'b0) $display("FAIL b2b_empty: got %b want 0", result_valid); else n_pass++;
      finish_op(got);
      n_checks++; if (got !== 1'b1) $display("FAIL b2b_done: got %b want 1", got); else n_pass++;
   endtask

   task automatic test_backpressure();
      int n_acc, first_stall;
      logic [31:0] got_q[$];
      bit got;
      do_start(3, 3, 0);
      load_weights(32'd1);
      result_ready = 1'b0;
      n_acc = 0;
      first_stall = -1;
      for (int c = 0; c < 10; c++) begin
         for (int t = 0; t < WS; t++) window[t] = 32'(n_acc + 1);
         window_valid = 1'b1;
         if (window_stall === 1'b0) n_acc++;
         else if (first_stall < 0) first_stall = c;
         tick();
      end
      n_checks++; if (n_acc !== 4) $display("FAIL bp_accepts: got %0d want 4", n_acc); else n_pass++;
      n_checks++; if (first_stall !== 4) $display("FAIL bp_stall_cycle: got %0d want 4", first_stall); else n_pass++;
      n_checks++; if (window_stall !== 1'b1) $display("FAIL bp_stall_held: got %b want 1", window_stall); else n_pass++;
      window_valid = 1'b0;
      result_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (result_valid === 1'b1) got_q.push_back(result_data);
         tick();
      end
      n_checks++; if (got_q.size() != 4) $display("FAIL bp_count: got %0d want 4", got_q.size()); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (i >= got_q.size() || got_q[i] !== 32'(9 * (i + 1)))
            $display("FAIL bp_order%0d: got %0d want %0d", i, (i < got_q.size()) ? got_q[i] : 32'hx, 9 * (i + 1));
         else n_pass++;
      end
      finish_op(got);
      n_checks++; if (got !== 1'b1) $display("FAIL bp_done: got %b want 1", got); else n_pass++;
   endtask

   task automatic test_finish_same_cycle();
      bit ok;
      logic [31:0] d;
      do_start(3, 3, 0);
      load_weights(32'd1);
      for (int t = 0; t < WS; t++) window[t] = 32'd2;
      result_ready  = 1'b0;
      window_valid  = 1'b1;
      window_finish = 1'b1;
      n_checks++; if (window_stall !== 1'b0) $display("FAIL fin_stall: got %b want 0", window_stall); else n_pass++;
      tick();
      window_valid = 1'b0;
      wait_result(ok, d);
      n_checks++; if (!ok || d !== 32'd18) $display("FAIL fin_data: got %0d (valid %b) want 18", d, ok); else n_pass++;
      result_ready = 1'b1;
      tick();
      n_checks++; if (done !== 1'b1) $display("FAIL fin_done: got %b want 1", done); else n_pass++;
      n_checks++; if (result_valid !== 1'b0) $display("FAIL fin_one_result: got %b want 0", result_valid); else n_pass++;
      tick();
      n_checks++; if (done !== 1'b0) $display("FAIL fin_done_pulse: got %b want 0", done); else n_pass++;
      n_checks++; if (window_stall !== 1'b1) $display("FAIL fin_idle: got %b want 1", window_stall); else n_pass++;
      window_finish = 1'b0;
      result_ready  = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit ok, got, seen;
      logic [31:0] d;
      do_start(3, 3, 0);
      wt_valid = 1'b1;
      wt_data  = 32'd5;
      repeat (4) tick();
      wt_valid = 1'b0;
      rst = 1'b1;
      tick();
      n_checks++; if (wt_ready !== 1'b0) $display("FAIL rl_wt_ready: got %b want 0", wt_ready); else n_pass++;
      n_checks++; if (window_stall !== 1'b1) $display("FAIL rl_stall: got %b want 1", window_stall); else n_pass++;
      rst = 1'b0;
      do_start(3, 3, 0);
      load_weights(32'd1);
      for (int t = 0; t < WS; t++) window[t] = 32'd1;
      window_valid = 1'b1;
      tick();
      for (int t = 0; t < WS; t++) window[t] = 32'd2;
      tick();
      window_valid = 1'b0;
      tick();
      n_checks++; if (result_valid !== 1'b1 || result_data !== 32'd9) $display("FAIL rr_pre: got %0d (valid %b) want 9", result_data, result_valid); else n_pass++;
      rst = 1'b1;
      tick();
      n_checks++; if (result_valid !== 1'b0) $display("FAIL rr_rvalid: got %b want 0", result_valid); else n_pass++;
      n_checks++; if (result_data !== 32'h0) $display("FAIL rr_rdata: got %h want 0", result_data); else n_pass++;
      n_checks++; if (window_stall !== 1'b1 || wt_ready !== 1'b0 || done !== 1'b0)
         $display("FAIL rr_ctrl: got stall %b wt_ready %b done %b want 1 0 0", window_stall, wt_ready, done);
      else n_pass++;
      rst = 1'b0;
      seen = 1'b0;
      repeat (5) begin
         tick();
         if (result_valid !== 1'b0) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b0) $display("FAIL rr_flushed: got %b want 0", seen); else n_pass++;
      for (int t = 0; t < WS; t++) window[t] = 32'(t + 1);
      run_single(3, 3, 0, 32'd1, ok, d, got);
      n_checks++; if (!ok || d !== 32'd45) $display("FAIL rr_fresh: got %0d (valid %b) want 45", d, ok); else n_pass++;
      n_checks++; if (got !== 1'b1) $display("FAIL rr_fresh_done: got %b want 1", got); else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass = 0;
      rst = 1'b1;
      start = 1'b0;
      wt_valid = 1'b0;
      wt_data = '0;
      window = '0;
      window_valid = 1'b0;
      window_finish = 1'b0;
      result_ready = 1'b0;
      kernel_width_i = '0;
      kernel_height_i = '0;
      shift_i = '0;
      test_reset();
      test_ones();
      test_mask();
      test_saturation();
      test_back_to_back();
      test_backpressure();
      test_finish_same_cycle();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
